mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Responder end of the core memory bus: receives addr/din/write_en from the core, returns dout.
//   Backs a word RAM plus an MMIO window: status, TX byte FIFO, free-running timer, scratch.
//   The TX FIFO drains over a ready/valid byte stream to an external sink (UART/host link).
//   The core has no stall: reads are combinational, writes commit at the clock edge.
// PARAMETERS
//   RAM_WORDS   1024  RAM depth in 32-bit words; power of two
//   FIFO_DEPTH  8     TX FIFO depth in bytes; power of two, >= 2
// PORTS
//   clk       in   1   clock
//   rst       in   1   synchronous reset, active-high
//   addr      in   32  byte address from core (word_t); addr[1:0] ignored
//   din       in   32  write data from core (word_t)
//   write_en  in   1   write strobe; commits at rising edge of clk
//   dout      out  32  read data to core (word_t); combinational from addr and current state
//   tx_data   out  8   FIFO head byte; valid only while tx_valid=1
//   tx_valid  out  1   FIFO non-empty
//   tx_ready  in   1   sink accepts; pop when tx_valid && tx_ready
// BEHAVIOUR
//   Map: addr[31]=0 -> RAM, index addr[2+:log2(RAM_WORDS)], upper bits aliased.
//        addr[31]=1 -> MMIO, offset addr[3:2]: 0 STATUS, 1 TX_DATA, 2 TIMER, 3 SCRATCH.
//   RAM: write at edge when write_en=1. Same-cycle read returns old word; new word next cycle.
//        Contents are not reset.
//   STATUS read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] level, others 0.
//          write: bit2=1 clears overflow (W1C); all other bits ignored.
//   TX_DATA write: pushes din[7:0]. Reads return 0.
//   TIMER: +1 every cycle, wraps 0xFFFF_FFFF->0. Write loads din; that value reads next cycle,
//          then the count resumes.
//   SCRATCH: plain R/W 32-bit register.
//   FIFO:
//     - Registered output. Push into an empty FIFO -> tx_valid=1 on the following cycle.
//     - Push accepted when !full, or when full and a pop happens in the same cycle (level unchanged).
//     - A push that is not accepted is dropped and sets overflow. If the same cycle's write is
//       W1C, set wins.
//     - Push and pop in the same cycle with 0<level<FIFO_DEPTH: level unchanged.
//     - Pointers wrap modulo FIFO_DEPTH. Level is a log2(FIFO_DEPTH)+1 bit counter.
//   Reset (edge with rst=1): FIFO empty, tx_valid=0, overflow=0, TIMER=0, SCRATCH=0.
//     - write_en ignored during reset; RAM is unchanged.
//     - A queued byte is discarded even mid-handshake.
//     - dout stays combinational and reflects reset state: STATUS reads 0x0000_0002.
//   tx_data is held stable while tx_valid && !tx_ready.
// CONFIGURATION
//   MEM_RESPONDER_TIMER_EN defined: TIMER behaves as above.
//   Not defined: no counter is built; TIMER reads 0; writes to it are ignored.
// STRUCTURE
//   types.sv package adds:
//     - MMIO_BASE = 32'h8000_0000
//     - mmio_reg_t enum {MMIO_STATUS, MMIO_TX_DATA, MMIO_TIMER, MMIO_SCRATCH}
//     - STATUS bit index constants
//   Sub-module tx_fifo (params WIDTH=8, DEPTH):
//     - ports push/push_data/full, pop/pop_data/empty, level.
//   mem_responder keeps address decode, RAM, MMIO regs and the dout mux.
// TESTING
//   1. Write 0xDEAD_BEEF @0x10, then read @0x10 same cycle -> old value; next cycle -> 0xDEAD_BEEF;
//      read @0x10+4*RAM_WORDS -> 0xDEAD_BEEF (alias).
//   2. tx_ready=0; write 0x41,0x42,0x43 to 0x8000_0004 -> STATUS level=3; tx_valid=1 and
//      tx_data=0x41 one cycle after the first push.
//      tx_ready=1 -> sink receives 0x41,0x42,0x43 in order, then STATUS=0x0000_0002.
//   3. Fill 8 bytes with tx_ready=0, push a 9th -> dropped, STATUS=0x0000_0805.
//      Push while full with tx_ready=1 -> accepted, level stays 8.
//      Write STATUS=0x4 -> overflow clears.
//   4. TIMER_EN: write 0xFFFF_FFFE to 0x8000_0008 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0, 1 on
//      consecutive cycles. Without macro: reads 0.
//   5. Push 3 bytes, assert rst for 1 cycle -> tx_valid=0, STATUS=0x0000_0002, SCRATCH=0;
//      RAM word written earlier is intact.
//   6. Read unmapped RAM-alias/MMIO combos: TX_DATA read -> 0; SCRATCH write 0x1234 -> reads 0x1234.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared types and constants for the core-memory responder:
//                bus word type, MMIO window base, MMIO register map and
//                STATUS register bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    typedef logic [31:0] word_t;

    // Any address with bit 31 set falls in the MMIO window.
    localparam word_t c_MMIO_BASE = 32'h8000_0000;

    // MMIO register selected by addr[3:2].
    typedef enum logic [1:0] {
        MMIO_STATUS  = 2'd0,
        MMIO_TX_DATA = 2'd1,
        MMIO_TIMER   = 2'd2,
        MMIO_SCRATCH = 2'd3
    } mmio_reg_t;

    // STATUS register layout.
    localparam int c_STAT_FULL      = 0;
    localparam int c_STAT_EMPTY     = 1;
    localparam int c_STAT_OVF       = 2;
    localparam int c_STAT_LEVEL_LSB = 8;
    localparam int c_STAT_LEVEL_W   = 8;

    // True when the address decodes into the MMIO window.
    function automatic logic is_mmio(input word_t a);
        return (a & c_MMIO_BASE) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_tx_fifo
//  Description : Synchronous FIFO for the TX byte stream. Head entry is
//                presented on pop_data straight from registered storage.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                push/push_data - write request and data
//                full           - level == DEPTH
//                pop/pop_data   - read request and head entry
//                empty          - level == 0
//                level          - occupancy, log2(DEPTH)+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_LEVEL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty    = (r_level == '0);
    assign full     = (r_level == c_FULL_LEVEL);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];

    // When full, wr_ptr == rd_ptr: a simultaneous pop frees exactly the slot
    // the push writes, so the push can be accepted.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (c_AW + 1)'(1);
                2'b01:   r_level <= r_level - (c_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Responder end of the core memory bus. Backs a word RAM
//                (addr[31]=0) and an MMIO window (addr[31]=1) holding STATUS,
//                TX_DATA (byte FIFO push), TIMER and SCRATCH. The TX FIFO
//                drains over a ready/valid byte stream. Reads are
//                combinational; writes commit at the rising clock edge.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                addr, din         - byte address and write data from core
//                write_en          - write strobe
//                dout              - combinational read data
//                tx_data/tx_valid  - FIFO head byte / FIFO non-empty
//                tx_ready          - sink accepts the head byte
//  Config      : MEM_RESPONDER_TIMER_EN - builds the free-running TIMER;
//                when undefined TIMER reads 0 and ignores writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        write_en,
    output logic [31:0] dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int c_RAM_AW = $clog2(RAM_WORDS);
    localparam int c_LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic                w_is_mmio;
    mmio_reg_t           w_reg;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_wr;
    logic                w_ram_we;
    logic                w_reg_we;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_LVL_W-1:0]  w_level;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic                r_ovf;
    logic [31:0]         r_scratch;
    logic [31:0]         w_timer;
    logic [31:0]         w_status;
    logic [31:0]         r_ram [RAM_WORDS];

    // ---------------- address decode ----------------
    assign w_is_mmio = is_mmio(addr);
    assign w_reg     = mmio_reg_t'(addr[3:2]);
    assign w_ram_idx = addr[2 +: c_RAM_AW];

    // Writes are suppressed while reset is asserted.
    assign w_wr     = write_en && !rst;
    assign w_ram_we = w_wr && !w_is_mmio;
    assign w_reg_we = w_wr && w_is_mmio;

    // ---------------- RAM (contents not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= din;
        end
    end

    // ---------------- TX FIFO ----------------
    assign w_push   = w_reg_we && (w_reg == MMIO_TX_DATA);
    assign w_pop    = tx_valid && tx_ready;
    assign tx_valid = !w_empty;

    mem_responder_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (din[7:0]),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (tx_data),
        .empty     (w_empty),
        .level     (w_level)
    );

    // ---------------- sticky overflow, W1C ----------------
    // A dropped push and a clear in the same cycle: the set wins.
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_ovf_clr = w_reg_we && (w_reg == MMIO_STATUS) && din[c_STAT_OVF];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ---------------- SCRATCH ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch <= '0;
        end else if (w_reg_we && (w_reg == MMIO_SCRATCH)) begin
            r_scratch <= din;
        end
    end

    // ---------------- TIMER ----------------
`ifdef MEM_RESPONDER_TIMER_EN
    logic [31:0] r_timer;

    // A load takes the place of that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_reg_we && (w_reg == MMIO_TIMER)) begin
            r_timer <= din;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        w_status                                    = '0;
        w_status[c_STAT_FULL]                       = w_full;
        w_status[c_STAT_EMPTY]                      = w_empty;
        w_status[c_STAT_OVF]                        = r_ovf;
        w_status[c_STAT_LEVEL_LSB +: c_STAT_LEVEL_W] = c_STAT_LEVEL_W'(w_level);
    end

    always_comb begin
        dout = '0;
        if (w_is_mmio) begin
            case (w_reg)
                MMIO_STATUS:  dout = w_status;
                MMIO_TX_DATA: dout = '0;
                MMIO_TIMER:   dout = w_timer;
                MMIO_SCRATCH: dout = r_scratch;
                default:      dout = '0;
            endcase
        end else begin
            dout = r_ram[w_ram_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. A behavioural model
//                (queue-based FIFO, associative RAM, plain registers) predicts
//                dout, tx_valid and tx_data every sampled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;

    localparam logic [31:0] A_STATUS  = 32'h8000_0000;
    localparam logic [31:0] A_TXD     = 32'h8000_0004;
    localparam logic [31:0] A_TIMER   = 32'h8000_0008;
    localparam logic [31:0] A_SCRATCH = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] din;
    logic        write_en;
    logic [31:0] dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .din      (din),
        .write_en (write_en),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [31:0] m_ram [int];

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        int idx;
        known = 1'b1;
        idx   = int'((a >> 2) % RAM_WORDS);
        if (!a[31]) begin
            if (m_ram.exists(idx)) return m_ram[idx];
            known = 1'b0;
            return 32'h0;
        end
        case (a[3:2])
            2'd0: return {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
                          (m_q.size() == 0), (m_q.size() == FIFO_DEPTH)};
            2'd1: return 32'h0;
`ifdef MEM_RESPONDER_TIMER_EN
            2'd2: return m_timer;
`else
            2'd2: return 32'h0;
`endif
            default: return m_scratch;
        endcase
    endfunction

    // Applies one clock edge's worth of effects using the current inputs.
    task automatic model_edge();
        int lvl;
        bit pop, push, set_ovf, clr_ovf;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0; m_timer = 32'h0; m_scratch = 32'h0;
            return;
        end
        lvl     = m_q.size();
        pop     = (lvl > 0) && tx_ready;
        push    = write_en && addr[31] && (addr[3:2] == 2'd1);
        set_ovf = push && (lvl == FIFO_DEPTH) && !pop;
        clr_ovf = write_en && addr[31] && (addr[3:2] == 2'd0) && din[2];
        if (pop) void'(m_q.pop_front());
        if (push && !set_ovf) m_q.push_back(din[7:0]);
        if (set_ovf) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (write_en && addr[31] && (addr[3:2] == 2'd2)) m_timer = din;
        else m_timer = m_timer + 32'd1;
        if (write_en && addr[31] && (addr[3:2] == 2'd3)) m_scratch = din;
        if (write_en && !addr[31]) m_ram[int'((addr >> 2) % RAM_WORDS)] = din;
    endtask

    // ---------------- drive helpers ----------------
    task automatic set_in(input logic [31:0] a, input logic [31:0] d,
                          input logic we, input logic rdy, input logic r);
        @(negedge clk);
        addr = a; din = d; write_en = we; tx_ready = rdy; rst = r;
        #1;
    endtask

    task automatic commit();
        model_edge();
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1); commit();
        set_in(A_SCRATCH, 32'hFFFF, 1'b1, 1'b0, 1'b1); commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (dout !== 32'h0000_0002) begin
            n_fail++; $display("FAIL reset_status: dout=%h expected %h", dout, 32'h2);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        commit();
        set_in(A_SCRATCH, 32'h0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL reset_scratch: dout=%h expected 0", dout);
        end
        commit();
        set_in(A_TIMER, 32'h0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL reset_timer: dout=%h expected 0", dout);
        end
        commit();
    endtask

    task automatic test_ram();
        set_in(32'h10, 32'h1111_1111, 1'b1, 1'b0, 1'b0); commit();
        set_in(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h1111_1111) begin
            n_fail++; $display("FAIL ram_same_cycle: dout=%h expected %h", dout, 32'h1111_1111);
        end
        commit();
        set_in(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_next_cycle: dout=%h expected %h", dout, 32'hDEAD_BEEF);
        end
        commit();
        set_in(32'h10 + 4 * RAM_WORDS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_alias: dout=%h expected %h", dout, 32'hDEAD_BEEF);
        end
        commit();
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp_b [3];
        int got;
        exp_b = '{8'h41, 8'h42, 8'h43};
        got   = 0;
        set_in(A_TXD, 32'h41, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_TXD, 32'h42, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            n_fail++; $display("FAIL fifo_first_valid: valid=%b data=%h expected 1/41", tx_valid, tx_data);
        end
        commit();
        set_in(A_TXD, 32'h43, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0300) begin
            n_fail++; $display("FAIL fifo_level3: dout=%h expected %h", dout, 32'h300);
        end
        commit();
        for (int c = 0; c < 10 && got < 3; c++) begin
            set_in(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0);
            if (tx_valid === 1'b1) begin
                n_tests++;
                if (tx_data !== exp_b[got]) begin
                    n_fail++; $display("FAIL fifo_order[%0d]: data=%h expected %h", got, tx_data, exp_b[got]);
                end
                got++;
            end
            commit();
        end
        n_tests++;
        if (got != 3) begin
            n_fail++; $display("FAIL fifo_drain_count: got %0d expected 3", got);
        end
        set_in(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0002) begin
            n_fail++; $display("FAIL fifo_empty_status: dout=%h expected %h", dout, 32'h2);
        end
        commit();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            set_in(A_TXD, 32'h60 + i, 1'b1, 1'b0, 1'b0); commit();
        end
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0801) begin
            n_fail++; $display("FAIL ovf_full: dout=%h expected %h", dout, 32'h801);
        end
        commit();
        set_in(A_TXD, 32'h99, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0805) begin
            n_fail++; $display("FAIL ovf_dropped: dout=%h expected %h", dout, 32'h805);
        end
        commit();
        set_in(A_TXD, 32'h77, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (tx_data !== 8'h60) begin
            n_fail++; $display("FAIL ovf_head: data=%h expected 60", tx_data);
        end
        commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0805 || tx_data !== 8'h61) begin
            n_fail++; $display("FAIL ovf_push_pop_full: dout=%h data=%h expected 805/61", dout, tx_data);
        end
        commit();
        set_in(A_STATUS, 32'h4, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0801) begin
            n_fail++; $display("FAIL ovf_w1c: dout=%h expected %h", dout, 32'h801);
        end
        commit();
        for (int c = 0; c < 20 && m_q.size() > 0; c++) begin
            set_in(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== m_q[0]) begin
                n_fail++; $display("FAIL ovf_drain: valid=%b data=%h expected 1/%h", tx_valid, tx_data, m_q[0]);
            end
            commit();
        end
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0002) begin
            n_fail++; $display("FAIL ovf_drained_status: dout=%h expected %h", dout, 32'h2);
        end
        commit();
    endtask

    task automatic test_timer();
        logic [31:0] exp_t [4];
`ifdef MEM_RESPONDER_TIMER_EN
        exp_t = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
`else
        exp_t = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        set_in(A_TIMER, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0); commit();
        for (int i = 0; i < 4; i++) begin
            set_in(A_TIMER, 32'h0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (dout !== exp_t[i]) begin
                n_fail++; $display("FAIL timer[%0d]: dout=%h expected %h", i, dout, exp_t[i]);
            end
            commit();
        end
    endtask

    task automatic test_reset_midflight();
        set_in(32'h20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_SCRATCH, 32'h55, 1'b1, 1'b0, 1'b0); commit();
        for (int i = 0; i < 3; i++) begin
            set_in(A_TXD, 32'hA0 + i, 1'b1, 1'b0, 1'b0); commit();
        end
        // Reset with the sink mid-handshake and a RAM write on the bus.
        set_in(32'h20, 32'h0BAD, 1'b1, 1'b1, 1'b1); commit();
        set_in(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0002 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_status: dout=%h valid=%b expected 2/0", dout, tx_valid);
        end
        commit();
        set_in(A_SCRATCH, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_scratch: dout=%h expected 0", dout);
        end
        commit();
        set_in(32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL rst_mid_ram20: dout=%h expected %h", dout, 32'hCAFE_F00D);
        end
        commit();
        set_in(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rst_mid_ram10: dout=%h expected %h", dout, 32'hDEAD_BEEF);
        end
        commit();
    endtask

    task automatic test_scratch();
        set_in(A_TXD, 32'h5A, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_TXD, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL txdata_read: dout=%h expected 0", dout);
        end
        commit();
        set_in(A_SCRATCH, 32'h1234, 1'b1, 1'b0, 1'b0); commit();
        set_in(A_SCRATCH, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h1234) begin
            n_fail++; $display("FAIL scratch_rw: dout=%h expected %h", dout, 32'h1234);
        end
        commit();
        set_in(32'hFFFF_FF0E, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h1234) begin
            n_fail++; $display("FAIL scratch_alias: dout=%h expected %h", dout, 32'h1234);
        end
        commit();
        set_in(32'h8765_4320, 32'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dout !== 32'h0000_0100) begin
            n_fail++; $display("FAIL status_alias: dout=%h expected %h", dout, 32'h100);
        end
        commit();
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp;
        logic        we, rdy, r;
        bit          known;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            d   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
            end else begin
                a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0)
                    | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            end
            set_in(a, d, we, rdy, r);
            exp = model_read(a, known);
            if (known) begin
                n_tests++;
                if (dout !== exp) begin
                    n_fail++; $display("FAIL rand_dout[%0d]: addr=%h dout=%h expected %h", n, a, dout, exp);
                end
            end
            n_tests++;
            if (tx_valid !== (m_q.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, tx_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                n_tests++;
                if (tx_data !== m_q[0]) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", n, tx_data, m_q[0]);
                end
            end
            commit();
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; din = '0; write_en = 1'b0; tx_ready = 1'b0;
        m_ovf = 1'b0; m_timer = '0; m_scratch = '0;
        test_reset();
        test_ram();
        test_fifo_order();
        test_overflow();
        test_timer();
        test_reset_midflight();
        test_scratch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
